reaction_scoreboard: RTL
========================

Name: reaction_scoreboard

Overview:
Parametrised score keeper for the reaction game: N players race to press a button when the round symbol equals a target. It handles round lockout, per-player BCD scores with reward and penalty, a configurable win threshold and game-over freeze. It sits between the symbol generator and the seven-segment/VGA display logic. It replaces the fixed two-player, two-digit scoring loop.

Parameters:
N_PLAYERS, 2, number of players/buttons (1..8)
DIGITS, 2, BCD digits per score (1..4)
SYM_W, 2, width of round symbol
TARGET_SYMBOL, 3, symbol value that rewards a press
WRAP, 1, 1: increment past all-9s wraps to 0; 0: saturate at all-9s
PENALTY, 1, 1: a press on a non-target symbol decrements the score; 0: no score change
WIN_SCORE, 0, decimal score that ends the game; 0 disables

Ports:
clk  input  1  system clock
clr  input  1  asynchronous reset, active-high
symbol  input  SYM_W  current round symbol, sampled when sym_valid=1
sym_valid  input  1  one-cycle pulse: a new round starts with symbol
btn  input  N_PLAYERS  player buttons, level, already synchronised to clk
score_clear  input  1  synchronous clear of scores and game state
scores  output  N_PLAYERS*DIGITS*4  packed BCD; player i occupies bits [(i+1)*DIGITS*4-1 : i*DIGITS*4]
round_open  output  1  1 while the round accepts a press
round_winner  output  3  index of the player who closed the last round
round_done  output  1  one-cycle pulse when a round closes
game_over  output  1  1 once any score equals WIN_SCORE
winner_id  output  3  index of the player who reached WIN_SCORE

Behaviour:
- Reset (clr=1, async): all scores 0, state IDLE, round_open=0, round_done=0, round_winner=0, game_over=0, winner_id=0, latched symbol=0, btn_q=all 1s. Presetting btn_q to 1s means a button held through reset is not counted.
- Edge detect: btn_q <= btn every cycle. press[i] = btn[i] & ~btn_q[i]. A held button counts once.
- States:
  - IDLE: round_open=0. On sym_valid, latch symbol and go to OPEN.
  - OPEN: round_open=1. On any press, the lowest-index pressing player p is scored at that clk edge. Set round_winner=p, pulse round_done, go to LOCKED. Other simultaneous presses are ignored.
  - LOCKED: round_open=0. Presses are ignored. On sym_valid, latch symbol and go to OPEN.
  - OVER: game_over=1. Scores are frozen. Presses and sym_valid are ignored. Only score_clear or clr leaves this state.
- Scoring, latency 1: the scores output reflects the press after the same edge that detected it.
  - Latched symbol == TARGET_SYMBOL: BCD increment, ripple carry across digits. From all-9s, wrap to 0 (WRAP=1) or hold (WRAP=0).
  - Otherwise with PENALTY=1: BCD decrement with borrow. Saturates at 0, so 0 stays 0 and 10 becomes 09.
  - Otherwise with PENALTY=0: score unchanged, but the round still closes.
- Win check:
  - If WIN_SCORE != 0 and the updated score equals WIN_SCORE (converted to BCD at elaboration), go to OVER and set winner_id=p, both on the same edge as the score update.
  - WIN_SCORE above the DIGITS range is a compile-time error.
- Simultaneous events:
  - sym_valid and a press in the same cycle: sym_valid wins. A new round opens with the new symbol, and the press is consumed without scoring.
  - score_clear: highest synchronous priority. Scores are zeroed, game_over=0, winner_id=0, state goes to IDLE, and any press or sym_valid in that cycle is dropped.
  - clr mid-round: immediate return to reset values.
- Width rules: player index outputs are 3 bits, zero-extended. Every BCD digit is always in the range 0..9.

Test Plan:
1. Reset, sym_valid with symbol=3, btn=01 rising → scores=0x0001 (P0=01) one edge later, round_winner=0, round_done pulse, round_open=0. Holding btn or pressing again leaves scores unchanged.
2. P1 score 10, sym_valid symbol=1, btn[1] rises → P1=09. Next round, symbol=1, P0 at 00 presses → P0 stays 00.
3. Same-cycle btn=11 on symbol=3 → only P0 increments, round_winner=0. Separately, sym_valid coincident with a press → round_open=1 and no score change.
4. WRAP=1, P0=99, target press → 00. WRAP=0 → stays 99. DIGITS=3 at 099 → 100.
5. WIN_SCORE=5, P1 at 04 wins a target round → P1=05, game_over=1, winner_id=1. Further sym_valid and presses are ignored. score_clear → all 0, IDLE.
6. clr asserted while OPEN → outputs go to reset values immediately. A button held through reset does not score after clr falls.

Source files
------------

// File: rtl/reaction_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reaction_scoreboard
// Description : Score keeper for the N-player reaction game. It handles round
//               open/lockout, per-player BCD scores with reward and penalty,
//               an optional win threshold and a game-over freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_scoreboard #(
    parameter int N_PLAYERS     = 2,
    parameter int DIGITS        = 2,
    parameter int SYM_W         = 2,
    parameter int TARGET_SYMBOL = 3,
    parameter bit WRAP          = 1'b1,
    parameter bit PENALTY       = 1'b1,
    parameter int WIN_SCORE     = 0
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [SYM_W-1:0]              symbol,
    input  logic                          sym_valid,
    input  logic [N_PLAYERS-1:0]          btn,
    input  logic                          score_clear,
    output logic [N_PLAYERS*DIGITS*4-1:0] scores,
    output logic                          round_open,
    output logic [2:0]                    round_winner,
    output logic                          round_done,
    output logic                          game_over,
    output logic [2:0]                    winner_id
);

    localparam int SW        = DIGITS * 4;
    localparam int MAX_SCORE = (10 ** DIGITS) - 1;

    // Decimal to packed BCD, evaluated at elaboration for the win threshold.
    function automatic logic [SW-1:0] to_bcd(input int value);
        logic [SW-1:0] r;
        int            v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    // Elaboration-time sanity checks on the configuration.
    generate
        if (WIN_SCORE < 0 || WIN_SCORE > MAX_SCORE) begin : g_bad_win_score
            $error("reaction_scoreboard: WIN_SCORE does not fit in DIGITS BCD digits");
        end
        if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_players
            $error("reaction_scoreboard: N_PLAYERS must be 1..8");
        end
        if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
            $error("reaction_scoreboard: DIGITS must be 1..4");
        end
    endgenerate

    // BCD +1 with ripple carry; a carry out of the top digit means the value
    // was all nines, so either wrap to zero or keep the original value.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            r = WRAP ? '0 : v;
        end
        return r;
    endfunction

    // BCD -1 with borrow, saturating at zero.
    function automatic logic [SW-1:0] bcd_dec(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        if (v == '0) begin
            borrow = 1'b0;
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (borrow) begin
                if (r[d*4 +: 4] == 4'd0) begin
                    r[d*4 +: 4] = 4'd9;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [N_PLAYERS*SW-1:0]         scores_q, scores_d;
    logic [SYM_W-1:0]                sym_q, sym_d;
    logic [N_PLAYERS-1:0]            btn_q, btn_d;
    logic [2:0]                      round_winner_q, round_winner_d;
    logic                            round_done_q, round_done_d;
    logic [2:0]                      winner_id_q, winner_id_d;

    logic [N_PLAYERS-1:0]            press;
    logic [2:0]                      press_idx;
    logic [SW-1:0]                   cur_score;
    logic [SW-1:0]                   new_score;

    // Rising-edge detect on the buttons and pick the lowest-index presser.
    always_comb begin
        btn_d     = btn;
        press     = btn & ~btn_q;
        press_idx = 3'd0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_idx = 3'(i);
            end
        end
    end

    // Next-state, scoring and win detection.
    always_comb begin
        state_d        = state_q;
        scores_d       = scores_q;
        sym_d          = sym_q;
        round_winner_d = round_winner_q;
        round_done_d   = 1'b0;
        winner_id_d    = winner_id_q;
        cur_score      = '0;

        for (int i = 0; i < N_PLAYERS; i++) begin
            if (3'(i) == press_idx) begin
                cur_score = scores_q[i*SW +: SW];
            end
        end

        if (sym_q == SYM_W'(TARGET_SYMBOL)) begin
            new_score = bcd_inc(cur_score);
        end else if (PENALTY) begin
            new_score = bcd_dec(cur_score);
        end else begin
            new_score = cur_score;
        end

        if (score_clear) begin
            // Clear outranks every other event in the same cycle.
            scores_d    = '0;
            winner_id_d = 3'd0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOCKED: begin
                    if (sym_valid) begin
                        sym_d   = symbol;
                        state_d = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (sym_valid) begin
                        // A new symbol restarts the round; a coincident
                        // press is swallowed by the edge detector.
                        sym_d = symbol;
                    end else if (|press) begin
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            if (3'(i) == press_idx) begin
                                scores_d[i*SW +: SW] = new_score;
                            end
                        end
                        round_winner_d = press_idx;
                        round_done_d   = 1'b1;
                        state_d        = ST_LOCKED;
                        if (WIN_SCORE != 0 && new_score == WIN_BCD) begin
                            state_d     = ST_OVER;
                            winner_id_d = press_idx;
                        end
                    end
                end
                ST_OVER: begin
                    // Frozen until score_clear or clr.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; buttons preset high so a held button
    // is not seen as a press when reset releases.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q        <= ST_IDLE;
            scores_q       <= '0;
            sym_q          <= '0;
            btn_q          <= '1;
            round_winner_q <= 3'd0;
            round_done_q   <= 1'b0;
            winner_id_q    <= 3'd0;
        end else begin
            state_q        <= state_d;
            scores_q       <= scores_d;
            sym_q          <= sym_d;
            btn_q          <= btn_d;
            round_winner_q <= round_winner_d;
            round_done_q   <= round_done_d;
            winner_id_q    <= winner_id_d;
        end
    end

    assign scores       = scores_q;
    assign round_open   = (state_q == ST_OPEN);
    assign game_over    = (state_q == ST_OVER);
    assign round_winner = round_winner_q;
    assign round_done   = round_done_q;
    assign winner_id    = winner_id_q;

endmodule
`default_nettype wire
